// File: rtl/bus_xfer_ctrl.sv
// Round-robin arbiter and single-beat transfer sequencer for a shared bidirectional data bus.
// Optional even parity on the data bus is compiled in with `define BUS_XFER_PARITY_EN.
`timescale 1ns/1ps
module bus_xfer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 2,
  parameter int TURN_CYC   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CH-1:0]            gnt,
  output logic [NUM_CH-1:0]            done,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [ADDR_WIDTH-1:0]        bus_addr,
  output logic                         bus_we,
  output logic                         bus_oe,
  inout  wire  [DATA_WIDTH-1:0]        bidr
`ifdef BUS_XFER_PARITY_EN
  ,
  inout  wire                          bidr_par,
  output logic                         par_err
`endif
);

  localparam int CW    = $clog2(NUM_CH);
  localparam int TC_M1 = (TURN_CYC > 0) ? TURN_CYC - 1 : 0;
  localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, TURN, XFER, DONE} state_t;

  state_t                state_reg;
  logic [CW-1:0]         ptr_reg;
  logic [CW-1:0]         win_reg;
  logic                  we_lat_reg;
  logic                  last_dir_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [2:0]            turn_cnt_reg;
  logic                  drive_reg;
`ifdef BUS_XFER_PARITY_EN
  logic                  par_bad_reg;
`endif

  logic [ADDR_WIDTH-1:0] ch_addr  [NUM_CH];
  logic [DATA_WIDTH-1:0] ch_wdata [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_addr[gi]  = addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign ch_wdata[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan from farthest to nearest so the nearest requester after ptr_reg wins.
  logic          pick_valid;
  logic [CW-1:0] pick_idx;
  logic [CW-1:0] cand;
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CW'((int'(ptr_reg) + k) % NUM_CH);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  logic pick_dir;
  logic turn_needed;
  assign pick_dir    = wr_en[pick_idx];
  assign turn_needed = (TURN_CYC > 0) && (pick_dir != last_dir_reg);

  assign bidr = drive_reg ? wdata_reg : {DATA_WIDTH{1'bz}};
`ifdef BUS_XFER_PARITY_EN
  assign bidr_par = drive_reg ? ^wdata_reg : 1'bz;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt          <= '0;
      done         <= '0;
      rdata        <= '0;
      bus_addr     <= '0;
      bus_we       <= 1'b0;
      bus_oe       <= 1'b0;
      drive_reg    <= 1'b0;
      ptr_reg      <= CW'(NUM_CH - 1);
      last_dir_reg <= 1'b0;
      win_reg      <= '0;
      we_lat_reg   <= 1'b0;
      wdata_reg    <= '0;
      turn_cnt_reg <= '0;
`ifdef BUS_XFER_PARITY_EN
      par_bad_reg  <= 1'b0;
      par_err      <= 1'b0;
`endif
    end else begin
      done <= '0;
`ifdef BUS_XFER_PARITY_EN
      par_err <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            win_reg    <= pick_idx;
            we_lat_reg <= pick_dir;
            bus_addr   <= ch_addr[pick_idx];
            wdata_reg  <= ch_wdata[pick_idx];
            gnt        <= ONE_HOT0 << pick_idx;
            if (turn_needed) begin
              state_reg    <= TURN;
              turn_cnt_reg <= 3'(TC_M1);
            end else begin
              state_reg <= XFER;
              bus_we    <= pick_dir;
              bus_oe    <= ~pick_dir;
              drive_reg <= pick_dir;
            end
          end
        end
        TURN: begin
          if (turn_cnt_reg == 3'd0) begin
            state_reg <= XFER;
            bus_we    <= we_lat_reg;
            bus_oe    <= ~we_lat_reg;
            drive_reg <= we_lat_reg;
          end else begin
            turn_cnt_reg <= turn_cnt_reg - 3'd1;
          end
        end
        XFER: begin
          state_reg <= DONE;
          bus_we    <= 1'b0;
          bus_oe    <= 1'b0;
          drive_reg <= 1'b0;
          if (!we_lat_reg) begin
            rdata <= bidr;
          end
`ifdef BUS_XFER_PARITY_EN
          par_bad_reg <= ~we_lat_reg && (bidr_par != ^bidr);
`endif
        end
        DONE: begin
          state_reg    <= IDLE;
          gnt          <= '0;
          done         <= ONE_HOT0 << win_reg;
          last_dir_reg <= we_lat_reg;
          ptr_reg      <= win_reg;
`ifdef BUS_XFER_PARITY_EN
          par_err     <= par_bad_reg;
          par_bad_reg <= 1'b0;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, which is the shared bidirectional data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, which is the bus address width.
REQ-003 SHALL have parameter NUM_CH, default 2 (range 2..8), which is the number of requester channels.
REQ-004 SHALL have parameter TURN_CYC, default 1 (range 0..7), which is the number of hi-Z turnaround cycles on a direction change.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-007 SHALL have port req, input, NUM_CH bits: per-channel transfer request.
REQ-008 SHALL have port wr_en, input, NUM_CH bits: per-channel direction, where 1 is write and 0 is read.
REQ-009 SHALL have port addr_in, input, NUM_CH*ADDR_WIDTH bits: per-channel address, with channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port wdata, input, NUM_CH*DATA_WIDTH bits: per-channel write data, packed the same way as addr_in.
REQ-011 SHALL have port gnt, output, NUM_CH bits: one-hot grant.
REQ-012 SHALL have port done, output, NUM_CH bits: one-cycle completion pulse for the granted channel.
REQ-013 SHALL have port rdata, output, DATA_WIDTH bits: the registered read result.
REQ-014 SHALL have port bus_addr, output, ADDR_WIDTH bits: the latched address of the granted channel.
REQ-015 SHALL have port bus_we, output, 1 bit: write strobe.
REQ-016 SHALL have port bus_oe, output, 1 bit: read strobe, asking the target to drive bidr.
REQ-017 SHALL have port bidr, inout, DATA_WIDTH bits: the shared bidirectional data bus.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, TURN, XFER and DONE.
REQ-019 In IDLE with any req bit high, the block SHALL pick a winner by round-robin, searching from the channel after the last granted one (modulo NUM_CH).
REQ-020 On acceptance, the block SHALL latch the winner's index, wr_en, addr_in and wdata; later changes on those inputs SHALL have no effect on the transfer.
REQ-021 From the cycle after acceptance through XFER, gnt SHALL be one-hot for the winner, and bus_addr SHALL hold the latched address.
REQ-022 Next state after acceptance SHALL be TURN when TURN_CYC>0 and the latched direction differs from the last completed direction; otherwise it SHALL be XFER.
REQ-023 TURN SHALL last exactly TURN_CYC cycles, with bidr hi-Z and bus_we=bus_oe=0, and then go to XFER.
REQ-024 XFER SHALL last one cycle. On a write, bidr SHALL be driven with the latched wdata and bus_we=1. On a read, bidr SHALL be hi-Z, bus_oe=1, and rdata SHALL capture bidr at the clock edge that ends XFER.
REQ-025 In DONE, the block SHALL clear gnt, pulse done[winner] for one cycle, update the last-direction register and the round-robin pointer, and go to IDLE.
REQ-026 Outside XFER-write, bidr SHALL never be driven by this block.
REQ-027 rdata SHALL hold its value until the next read completes; writes SHALL NOT modify it.
REQ-028 Latency SHALL be: acceptance edge to done pulse = 2 cycles without TURN, and 2+TURN_CYC cycles with TURN.
REQ-029 A req dropped before acceptance SHALL be ignored; a req dropped after acceptance SHALL NOT abort the transfer.
REQ-030 Back-to-back transfers: IDLE SHALL re-arbitrate in the cycle after DONE, giving a minimum of 3 cycles per transfer.
REQ-031 With all channels requesting continuously, grants SHALL rotate 0,1,...,NUM_CH-1,0, and no channel SHALL wait more than NUM_CH transfers.

Reset
REQ-032 While rst_n=0 at a clock edge, the block SHALL force: state=IDLE, gnt=0, done=0, rdata=0, bus_addr=0, bus_we=0, bus_oe=0, bidr hi-Z, RR pointer=NUM_CH-1 (so channel 0 wins first), last direction=read.
REQ-033 Reset asserted in any state SHALL abort the in-flight transfer with no done pulse; bidr SHALL be hi-Z from the first reset edge onward.

Configuration
REQ-034 The macro BUS_XFER_PARITY_EN SHALL compile in even parity support.
REQ-035 When BUS_XFER_PARITY_EN is defined, the block SHALL add port bidr_par (inout, 1 bit) and port par_err (output, 1 bit, reset 0).
REQ-036 When BUS_XFER_PARITY_EN is defined: on XFER-write, bidr_par SHALL be driven with ^wdata and otherwise be hi-Z; on a read, the block SHALL check bidr_par against ^bidr at the XFER edge, and par_err SHALL pulse in the DONE cycle on a mismatch.
REQ-037 When BUS_XFER_PARITY_EN is undefined, neither bidr_par nor par_err nor any parity logic SHALL exist.

Verification
REQ-038 With defaults, reset then req=2'b01, wr_en=2'b01, addr0=5'h03, wdata0=8'hA5: gnt=01 for 3 cycles, 1 TURN cycle (hi-Z), bidr=8'hA5 with bus_we=1 for 1 cycle, then done=01 pulse.
REQ-039 Read from channel 1 directly after that write, with the target driving 8'h3C in XFER: 1 TURN cycle, bus_oe=1 for 1 cycle, rdata=8'h3C, done=10.
REQ-040 Continuous req=2'b11, with all reads, over 4 transfers: grant order SHALL be 0,1,0,1, with no TURN cycles and 3 cycles per transfer.
REQ-041 rst_n=0 asserted during XFER-write: bidr SHALL be hi-Z, gnt=0 and done=0 at the next edge, and no done pulse SHALL be issued.
REQ-042 TURN_CYC=0 with alternating write/read: there SHALL be no TURN state, and bidr SHALL never be driven in a read XFER.
REQ-043 With BUS_XFER_PARITY_EN defined, a read where the target drives bidr=8'h01 and bidr_par=0 SHALL produce par_err=1 for exactly one cycle, coincident with done.
